// File: rtl/dmx_pkg.sv
// Shared DMX constants: slot space, PWM period and the receiver's line timing.
package dmx_pkg;

  localparam int DMX_SLOTS    = 512;
  localparam int CHANNEL_BITS = 9;
  localparam int PWM_STEPS    = 255;

  // Highest PWM count; the counter wraps from here back to zero.
  localparam logic [7:0] PWM_LAST = 8'd254;

  // Receiver line timing at a 48 MHz system clock (250 kbaud DMX512).
  localparam int CLOCK_HZ         = 48_000_000;
  localparam int BIT_CYCLES       = 192;   // 4 us per bit
  localparam int BREAK_MIN_CYCLES = 4224;  // 88 us minimum break
  localparam int MAB_MIN_CYCLES   = 384;   // 8 us minimum mark-after-break

  // Next PWM count in the 0..254 sequence.
  function automatic logic [7:0] pwm_step(input logic [7:0] count);
    if (count == PWM_LAST) begin
      pwm_step = 8'd0;
    end else begin
      pwm_step = count + 8'd1;
    end
  endfunction

endpackage

// File: rtl/dmx_pwm_timebase.sv
// PWM timebase: a prescaler producing count steps and a 0..254 duty counter.
// tick marks the last prescaler cycle of a step; wrap marks the last cycle of a period.
module dmx_pwm_timebase #(
  parameter int PRESCALE = 188
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] pwm_count,
  output logic       tick,
  output logic       wrap
);
  import dmx_pkg::*;

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] prescaler_r;
  logic [7:0]       count_r;

  assign tick      = (prescaler_r == PRE_LAST);
  assign wrap      = tick && (count_r == PWM_LAST);
  assign pwm_count = count_r;

  // Prescaler: counts 0..PRESCALE-1 and restarts after each tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler_r <= '0;
    end else if (tick) begin
      prescaler_r <= '0;
    end else begin
      prescaler_r <= prescaler_r + PRE_W'(1);
    end
  end

  // Duty counter: advances one step per tick through 0..254.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (tick) begin
      count_r <= pwm_step(count_r);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/dmx_pwm_bank.sv
// DMX-driven PWM bank. A window of DMX channels is captured into shadow registers;
// completed frames are copied to the active duty registers only at a PWM period
// boundary so no output sees a torn period. Loss of DMX blanks all outputs at once.
module dmx_pwm_bank #(
  parameter int CHANNEL_BITS  = dmx_pkg::CHANNEL_BITS,
  parameter int START_CHANNEL = 0,
  parameter int NUM_OUTPUTS   = 8,
  parameter int PRESCALE      = 188,
  parameter int LOSS_CYCLES   = 48_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              data,
  input  logic [CHANNEL_BITS-1:0] channel,
  input  logic                    write_strobe,
  output logic [NUM_OUTPUTS-1:0]  pwm_out,
  output logic                    frame_commit,
  output logic                    signal_lost
);
  import dmx_pkg::*;

  localparam int CW     = CHANNEL_BITS + 1;
  localparam int IDX_W  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int LOSS_W = $clog2(LOSS_CYCLES + 1);

  localparam logic [CW-1:0]     WIN_FIRST = CW'(START_CHANNEL);
  localparam logic [CW-1:0]     WIN_LEN   = CW'(NUM_OUTPUTS);
  localparam logic [CW-1:0]     WIN_LAST  = CW'(START_CHANNEL + NUM_OUTPUTS - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX  = LOSS_W'(LOSS_CYCLES);
  localparam logic [LOSS_W-1:0] LOSS_PRE  = LOSS_W'(LOSS_CYCLES - 1);

  logic [7:0]             pwm_count_s;
  logic                   tick_s;
  logic                   wrap_s;
  logic                   boundary_s;

  logic [CW-1:0]          chan_wide_s;
  logic [CW-1:0]          offset_s;
  logic [IDX_W-1:0]       slot_idx_s;
  logic                   in_window_s;
  logic                   window_done_s;
  logic                   new_frame_s;
  logic                   request_s;
  logic                   loss_event_s;
  logic                   load_s;
  logic [NUM_OUTPUTS-1:0] duty_hit_s;

  logic [7:0]             shadow_r [NUM_OUTPUTS];
  logic [7:0]             active_r [NUM_OUTPUTS];
  logic                   dirty_r;
  logic                   pending_r;
  logic [LOSS_W-1:0]      loss_cnt_r;

  dmx_pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clock     (clock),
    .reset     (reset),
    .pwm_count (pwm_count_s),
    .tick      (tick_s),
    .wrap      (wrap_s)
  );

  // A period ends on the final prescaler step of count 254.
  assign boundary_s = tick_s && wrap_s;

  // The offset is taken one bit wider than the channel. A channel below the
  // window wraps to a value >= 513, which is never below the window length.
  assign chan_wide_s   = {1'b0, channel};
  assign offset_s      = chan_wide_s - WIN_FIRST;
  assign slot_idx_s    = offset_s[IDX_W-1:0];
  assign in_window_s   = write_strobe && (offset_s < WIN_LEN);
  assign window_done_s = write_strobe && (chan_wide_s == WIN_LAST);
  assign new_frame_s   = write_strobe && (channel == '0) && dirty_r;
  assign request_s     = window_done_s || new_frame_s;

  // Loss fires on the edge the idle count reaches its limit; a strobe blocks it.
  assign loss_event_s  = !write_strobe && (loss_cnt_r == LOSS_PRE);
  assign load_s        = boundary_s && pending_r && !loss_event_s;

  // Idle counter: cleared by any strobe, otherwise counts up and saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      loss_cnt_r <= '0;
    end else if (write_strobe) begin
      loss_cnt_r <= '0;
    end else if (loss_cnt_r != LOSS_MAX) begin
      loss_cnt_r <= loss_cnt_r + LOSS_W'(1);
    end else begin
      loss_cnt_r <= loss_cnt_r;
    end
  end

  // Loss flag: raised when the idle limit is reached, dropped by the next strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      signal_lost <= 1'b0;
    end else if (write_strobe) begin
      signal_lost <= 1'b0;
    end else if (loss_event_s) begin
      signal_lost <= 1'b1;
    end else begin
      signal_lost <= signal_lost;
    end
  end

  // Shadow capture of in-window slots; survives signal loss.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        shadow_r[i] <= 8'd0;
      end
    end else if (in_window_s) begin
      shadow_r[slot_idx_s] <= data;
    end
  end

  // Dirty: shadow holds data not yet requested for commit. A request on the
  // same strobe wins so a completed window does not leave dirty behind.
  always_ff @(posedge clock) begin
    if (reset) begin
      dirty_r <= 1'b0;
    end else if (request_s) begin
      dirty_r <= 1'b0;
    end else if (in_window_s) begin
      dirty_r <= 1'b1;
    end else begin
      dirty_r <= dirty_r;
    end
  end

  // Pending commit: loss cancels it; a new request outlives a same-edge load
  // because that request's data is not part of the load.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_r <= 1'b0;
    end else if (loss_event_s) begin
      pending_r <= 1'b0;
    end else if (request_s) begin
      pending_r <= 1'b1;
    end else if (load_s) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Active duties: blanked immediately on loss, otherwise loaded at a boundary.
  always_ff @(posedge clock) begin
    if (reset || loss_event_s) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        active_r[i] <= 8'd0;
      end
    end else if (load_s) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        active_r[i] <= shadow_r[i];
      end
    end
  end

  // Commit pulse accompanies the cycle after active registers were loaded.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_commit <= 1'b0;
    end else begin
      frame_commit <= load_s;
    end
  end

  // Per-output duty compare; count tops out at 254 so duty 255 is always on.
  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_duty
    assign duty_hit_s[g] = (pwm_count_s < active_r[g]);
  end

  // Registered PWM outputs, one cycle behind the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= duty_hit_s;
    end
  end

endmodule

// File: tb/tb_dmx_pwm_bank.sv
// Bench for dmx_pwm_bank: two instances (8-wide window at 0 with PRESCALE 1,
// 4-wide window at 10 with PRESCALE 2) checked each cycle against a period/
// idle-time model, plus directed scenarios with hand-computed expectations.
module tb_dmx_pwm_bank;

  logic       clock;
  logic       reset;
  logic       stb [2];
  logic [8:0] chn [2];
  logic [7:0] dat [2];
  logic       fc  [2];
  logic       sl  [2];
  logic [7:0] pw_a;
  logic [3:0] pw_b;

  int cfg_start [2] = '{0, 10};
  int cfg_num   [2] = '{8, 4};
  int cfg_pre   [2] = '{1, 2};
  int cfg_loss  [2] = '{1000, 20000};

  int n_total = 0;
  int n_bad   = 0;
  int hi_cnt [8];

  dmx_pwm_bank #(
    .CHANNEL_BITS(9), .START_CHANNEL(0), .NUM_OUTPUTS(8), .PRESCALE(1), .LOSS_CYCLES(1000)
  ) dut_a (
    .clock(clock), .reset(reset), .data(dat[0]), .channel(chn[0]), .write_strobe(stb[0]),
    .pwm_out(pw_a), .frame_commit(fc[0]), .signal_lost(sl[0])
  );

  dmx_pwm_bank #(
    .CHANNEL_BITS(9), .START_CHANNEL(10), .NUM_OUTPUTS(4), .PRESCALE(2), .LOSS_CYCLES(20000)
  ) dut_b (
    .clock(clock), .reset(reset), .data(dat[1]), .channel(chn[1]), .write_strobe(stb[1]),
    .pwm_out(pw_b), .frame_commit(fc[1]), .signal_lost(sl[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- model ----------------
  bit         m_valid = 1'b0;
  int         m_n     [2];
  int         m_idle  [2];
  logic [7:0] m_shadow[2][8];
  logic [7:0] m_active[2][8];
  bit         m_dirty [2];
  bit         m_pending[2];
  bit         m_lost  [2];
  logic [7:0] m_pwm   [2];
  bit         m_commit[2];

  // Model: position in the period from elapsed cycles, loss from idle time.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      automatic int  per    = 255 * cfg_pre[k];
      automatic int  cnt    = (m_n[k] / cfg_pre[k]) % 255;
      automatic bit  wrap   = ((m_n[k] + 1) % per) == 0;
      automatic int  ch     = int'(chn[k]);
      automatic bit  in_win = stb[k] && ch >= cfg_start[k] && ch < cfg_start[k] + cfg_num[k];
      automatic bit  req    = stb[k] && (ch == cfg_start[k] + cfg_num[k] - 1 || (ch == 0 && m_dirty[k]));
      automatic bit  lossev = !stb[k] && (m_idle[k] + 1 == cfg_loss[k]);
      automatic bit  load   = wrap && m_pending[k] && !lossev;
      automatic logic [7:0] hit = 8'd0;
      for (int i = 0; i < cfg_num[k]; i++) hit[i] = (cnt < int'(m_active[k][i]));
      if (reset) begin
        m_n[k] <= 0; m_idle[k] <= 0; m_dirty[k] <= 1'b0; m_pending[k] <= 1'b0;
        m_lost[k] <= 1'b0; m_pwm[k] <= 8'd0; m_commit[k] <= 1'b0;
        for (int i = 0; i < 8; i++) begin
          m_shadow[k][i] <= 8'd0; m_active[k][i] <= 8'd0;
        end
      end else begin
        m_n[k]    <= m_n[k] + 1;
        m_idle[k] <= stb[k] ? 0 : ((m_idle[k] < cfg_loss[k]) ? m_idle[k] + 1 : m_idle[k]);
        m_lost[k] <= stb[k] ? 1'b0 : (lossev ? 1'b1 : m_lost[k]);
        if (in_win) m_shadow[k][ch - cfg_start[k]] <= dat[k];
        m_dirty[k]   <= req ? 1'b0 : (in_win ? 1'b1 : m_dirty[k]);
        m_pending[k] <= lossev ? 1'b0 : (req ? 1'b1 : (load ? 1'b0 : m_pending[k]));
        for (int i = 0; i < 8; i++) begin
          if (lossev) m_active[k][i] <= 8'd0;
          else if (load) m_active[k][i] <= m_shadow[k][i];
        end
        m_pwm[k]    <= hit;
        m_commit[k] <= load;
      end
    end
    if (reset) m_valid <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every output of both instances against the model.
  always @(negedge clock) begin
    if (m_valid) begin
      check("pwm_a",    32'(pw_a),  32'(m_pwm[0]));
      check("commit_a", 32'(fc[0]), 32'(m_commit[0]));
      check("lost_a",   32'(sl[0]), 32'(m_lost[0]));
      check("pwm_b",    32'(pw_b),  32'(m_pwm[1][3:0]));
      check("commit_b", 32'(fc[1]), 32'(m_commit[1]));
      check("lost_b",   32'(sl[1]), 32'(m_lost[1]));
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send(input int k, input int ch, input logic [7:0] v);
    chn[k] = 9'(ch); dat[k] = v; stb[k] = 1'b1;
    @(posedge clock); @(negedge clock);
    stb[k] = 1'b0;
  endtask

  task automatic wait_commit(input int k, input int max_c, output int waited);
    waited = 0;
    while (fc[k] !== 1'b1 && waited < max_c) begin
      @(negedge clock); waited++;
    end
    check("commit_seen", 32'(fc[k]), 32'd1);
  endtask

  task automatic measure(input int k, input int cycles);
    for (int i = 0; i < 8; i++) hi_cnt[i] = 0;
    repeat (cycles) begin
      @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        if ((k == 0) ? pw_a[i] : (i < 4 && pw_b[i % 4])) hi_cnt[i]++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    automatic int w;
    automatic int lost_k;
    automatic logic [7:0] t1 [8] = '{8'd0, 8'd1, 8'd64, 8'd128, 8'd200, 8'd254, 8'd255, 8'd0};
    for (int k = 0; k < 2; k++) begin
      stb[k] = 1'b0; chn[k] = 9'd0; dat[k] = 8'd0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_pwm_a", 32'(pw_a), 32'd0);
    check("reset_lost_a", 32'(sl[0]), 32'd0);
    reset = 1'b0;

    // 1: full frame with edge duties.
    for (int i = 0; i < 8; i++) send(0, i, t1[i]);
    wait_commit(0, 600, w);
    measure(0, 255);
    check("t1_d0", hi_cnt[0], 0);
    check("t1_d1", hi_cnt[1], 1);
    check("t1_d64", hi_cnt[2], 64);
    check("t1_d128", hi_cnt[3], 128);
    check("t1_d254", hi_cnt[5], 254);
    check("t1_d255", hi_cnt[6], 255);
    check("t1_d0_last", hi_cnt[7], 0);

    // 3: partial frame committed by a new channel 0.
    for (int i = 0; i < 4; i++) send(0, i, 8'h40);
    send(0, 0, 8'h10);
    wait_commit(0, 600, w);
    measure(0, 255);
    check("t3_ch0", hi_cnt[0], 16);
    check("t3_ch1", hi_cnt[1], 64);
    check("t3_ch4_kept", hi_cnt[4], 200);
    check("t3_ch6_kept", hi_cnt[6], 255);

    // 4: window-complete strobe landing exactly on the wrap edge.
    for (int i = 0; i < 7; i++) send(0, i, 8'hFF);
    while (((m_n[0] + 1) % 255) != 0) @(negedge clock);
    send(0, 7, 8'hFF);
    check("t4_no_commit_on_wrap", 32'(fc[0]), 32'd0);
    wait_commit(0, 400, w);
    check("t4_next_wrap", w, 255);
    @(negedge clock);
    check("t4_all_on", 32'(pw_a), 32'hFF);

    // 5: loss of DMX.
    send(0, 100, 8'h00);
    lost_k = -1;
    for (int kk = 1; kk <= 1100; kk++) begin
      @(negedge clock);
      if (kk == 999) begin
        check("t5_pre_pwm", 32'(pw_a), 32'hFF);
        check("t5_pre_lost", 32'(sl[0]), 32'd0);
      end
      if (lost_k < 0 && sl[0] === 1'b1) lost_k = kk;
      if (lost_k > 0 && kk == lost_k + 1) check("t5_dark", 32'(pw_a), 32'd0);
    end
    check("t5_loss_cycle", lost_k, 1000);
    send(0, 100, 8'h00);
    check("t5_lost_cleared", 32'(sl[0]), 32'd0);
    repeat (300) @(negedge clock);
    check("t5_still_dark", 32'(pw_a), 32'd0);
    for (int i = 0; i < 8; i++) send(0, i, 8'hFF);
    wait_commit(0, 600, w);
    @(negedge clock);
    check("t5_relit", 32'(pw_a), 32'hFF);

    // 6: reset in the middle of a frame.
    for (int i = 0; i < 4; i++) send(0, i, 8'h55);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    check("t6_pwm_zero", 32'(pw_a), 32'd0);
    check("t6_commit_zero", 32'(fc[0]), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) send(0, i, 8'h20);
    send(0, 7, 8'h80);
    wait_commit(0, 600, w);
    measure(0, 255);
    check("t6_ch0", hi_cnt[0], 32);
    check("t6_ch7", hi_cnt[7], 128);

    // 2: offset window on the second instance.
    send(1, 9, 8'hFF);
    send(1, 14, 8'hFF);
    w = 0;
    repeat (600) begin
      @(negedge clock);
      if (fc[1] === 1'b1) w++;
    end
    check("t2_no_commit", w, 0);
    check("t2_dark", 32'(pw_b), 32'd0);
    for (int i = 10; i < 14; i++) send(1, i, 8'h80);
    wait_commit(1, 1200, w);
    measure(1, 510);
    check("t2_out0", hi_cnt[0], 256);
    check("t2_out3", hi_cnt[3], 256);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
